// File: rtl/mux4_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// mux4_rr_arbiter_if
// Bundles the request/grant signals shared between four requesters and the
// round-robin arbiter that steers a 4:1 mux.
//   req    : request vector, one bit per requester (driven by requesters)
//   grant  : registered one-hot grant, all-zero when idle
//   sel    : binary mux select matching grant (holds its value while idle)
//   active : high whenever grant is non-zero
//   switch : one-cycle pulse in the first cycle of each new grant
// Modports:
//   master : requester side (drives req, observes the arbiter outputs)
//   slave  : arbiter side (observes req, drives grant/sel/active/switch)
// ----------------------------------------------------------------------------
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       active;
  logic       switch;

  modport master (
    output req,
    input  grant,
    input  sel,
    input  active,
    input  switch
  );

  modport slave (
    input  req,
    output grant,
    output sel,
    output active,
    output switch
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin arbiter for four requesters sharing one 4:1 mux datapath.
// The grant is registered and one-hot; sel is its binary encoding and drives
// the mux directly. A grant is capped at MAX_HOLD consecutive cycles while
// any other requester is waiting; an uncontended owner may hold forever.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : mux4_rr_arbiter_if.slave (req in; grant, sel, active, switch out)
// Parameters:
//   MAX_HOLD : maximum contended hold length in cycles, 1..255
// ----------------------------------------------------------------------------
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  mux4_rr_arbiter_if.slave   bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Terminal value of the hold counter; also its saturation point.
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  logic [0:0] state_reg,  state_next;
  logic [3:0] grant_reg,  grant_next;
  logic [1:0] sel_reg,    sel_next;
  logic       switch_reg, switch_next;
  logic [7:0] cnt_reg,    cnt_next;
  logic [1:0] last_reg,   last_next;

  logic [3:0] pool;         // candidates for the next grant
  logic       owner_keeps;  // current owner is still requesting
  logic       timeout;      // owner has used its full slot and someone waits
  logic       found;
  logic [1:0] winner;
  logic [1:0] idx;

  always_comb begin
    // In GRANT the owner is masked out so it can never re-win against itself;
    // in IDLE every requester is a candidate.
    pool        = (state_reg == ST_GRANT) ? (bus.req & ~grant_reg) : bus.req;
    owner_keeps = (state_reg == ST_GRANT) && (|(bus.req & grant_reg));
    timeout     = owner_keeps && (|pool) && (cnt_reg == HOLD_LIMIT);

    // Scan from lowest priority (last) to highest (last+1) so the last hit
    // is the round-robin winner. The 2-bit index wraps modulo 4 by itself.
    found  = 1'b0;
    winner = 2'd0;
    idx    = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = last_reg + 2'(k);
      if (pool[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end

    state_next  = state_reg;
    grant_next  = grant_reg;
    sel_next    = sel_reg;
    switch_next = 1'b0;
    cnt_next    = cnt_reg;
    last_next   = last_reg;

    if (owner_keeps && !timeout) begin
      // Keep the grant; counter saturates so an uncontended owner is
      // pre-empted on the first contended cycle once its slot is used up.
      cnt_next = (cnt_reg == HOLD_LIMIT) ? cnt_reg : cnt_reg + 8'd1;
    end else if (found) begin
      // New grant: from IDLE, on release, or on timeout. No dead cycle.
      state_next  = ST_GRANT;
      grant_next  = 4'b0001 << winner;
      sel_next    = winner;
      last_next   = winner;
      cnt_next    = 8'd0;
      switch_next = 1'b1;
    end else begin
      // Nobody left requesting; sel holds so the mux output stays stable.
      state_next = ST_IDLE;
      grant_next = 4'b0000;
      cnt_next   = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      grant_reg  <= 4'b0000;
      sel_reg    <= 2'd0;
      switch_reg <= 1'b0;
      cnt_reg    <= 8'd0;
      last_reg   <= 2'd3;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      sel_reg    <= sel_next;
      switch_reg <= switch_next;
      cnt_reg    <= cnt_next;
      last_reg   <= last_next;
    end
  end

  assign bus.grant  = grant_reg;
  assign bus.sel    = sel_reg;
  assign bus.active = |grant_reg;
  assign bus.switch = switch_reg;

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 mux datapath between four requesters.
- Registers a one-hot grant and drives the mux `sel` directly from it.
- Caps each grant at MAX_HOLD consecutive cycles while other requesters are waiting.
- Sits beside the 4:1 mux: `sel` connects to the mux `sel`, and `grant` is returned to the requesters.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one requester keeps the grant while another requester is asserting; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  request vector; req[i] high = requester i wants the mux
- grant  output  4  registered one-hot grant; all-zero when idle
- sel  output  2  mux select; binary encoding of grant
- active  output  1  high whenever grant is non-zero
- switch  output  1  one-cycle pulse in the cycle a new grant first appears

Behaviour:
- Reset (rst high at a clock edge):
  - grant=0000, sel=00, active=0, switch=0.
  - State=IDLE, hold counter cnt=0, last-granted pointer last=3, so requester 0 has first priority.
  - Reset takes effect mid-grant with no completion of the current grant.
- States: IDLE, GRANT.
- Round-robin pick:
  - Search req from index (last+1) mod 4 upward with wrap-around.
  - The first set bit wins. On a new grant, last updates to the winner.
- IDLE:
  - If req=0000, stay in IDLE with grant=0000.
  - If any req is set, go to GRANT next edge with grant=onehot(winner), active=1, switch=1, cnt=0.
  - Latency from req rising to grant is exactly 1 cycle.
- GRANT, with current owner g (others = req with bit g masked):
  - Release: if req[g]=0, grant the round-robin winner among the others at the next edge (no dead cycle), with switch=1 and cnt=0. If others=0, go to IDLE with grant=0000 and active=0.
  - Timeout: if req[g]=1, cnt==MAX_HOLD-1 and others≠0, switch to the round-robin winner at the next edge, with switch=1 and cnt=0.
  - Uncontended hold: if req[g]=1 and others=0, keep the grant indefinitely. cnt saturates at MAX_HOLD-1, and a timeout fires on the first contended cycle after that.
  - Otherwise cnt increments by 1.
- Grant timing:
  - A grant lasts between 1 and MAX_HOLD cycles when contended.
  - MAX_HOLD=1 rotates the grant every cycle under contention.
- sel:
  - sel = encode(grant) when active=1.
  - When IDLE, sel holds its last value (00 after reset) so the mux output does not glitch.
- Output invariants:
  - grant is always zero or one-hot.
  - switch is high only in the first cycle of each grant.
  - Requests are sampled only at clock edges; pulses shorter than a cycle between edges are ignored.
- Width: cnt is 8 bits, compared against MAX_HOLD-1.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=1111 -> grant=0000, sel=00, active=0, switch=0 throughout.
- Single requester: req=0100 from cycle 0, held for 10 cycles -> grant=0100, sel=10 from cycle 1, switch pulses once, grant held all 10 cycles. Then req=0000 -> next cycle grant=0000 and sel stays 10.
- Full contention: req=1111 held, MAX_HOLD=4 -> grant sequence 0001×4, 0010×4, 0100×4, 1000×4, 0001…; sel steps 00,01,10,11; switch pulses every 4 cycles.
- Early release: req=0011; owner 0 drops req[0] after 2 cycles -> grant goes to 0010 on the next edge with no idle cycle between grants.
- Fairness after wrap: last=3, req=1001 -> requester 0 is granted first. After owner 0 releases or times out, requester 3 is granted.
- Mid-grant reset: req=1111 with owner 1 at cnt=2; assert rst for 1 cycle -> grant=0000 on that edge. After rst drops, requester 0 is granted first because last=3.
